// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and set-2 scan-code decoder; builds held arrow-key state for the game core.
// Latency: scan_code/code_valid/button update 1 clk after the filtered falling edge that samples the stop bit.
// Backpressure: none; PS/2 is device-clocked, so every byte is consumed on arrival and strobes are single-cycle.
// Optional WASD_ALIAS_EN: non-extended A/D/S/W also drive left/right/down/up through their own held flags.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] button,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  // Decoder states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  // Set-2 prefix bytes
  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  // Synchronizer stages (idle PS/2 lines are high)
  logic          clk_s1, clk_s2;
  logic          dat_s1, dat_s2;

  // Clock filter
  logic          filt_lvl;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  // Receiver
  logic [9:0]    shreg;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] to_cnt;
  logic [10:0]   frame_w;
  logic [7:0]    rx_byte;
  logic          last_bit;
  logic          frame_ok;
  logic          byte_vld;
  logic          byte_bad;
  logic          to_expire;

  // Decoder
  logic [1:0]    state, state_nx;
  logic [3:0]    arr_held, arr_nx;

  // Arrow keys arrive with the E0 prefix; one bit per direction.
  function automatic logic [3:0] arrow_mask(input logic [7:0] b);
    case (b)
      8'h6B:   arrow_mask = 4'b0001;
      8'h74:   arrow_mask = 4'b0010;
      8'h72:   arrow_mask = 4'b0100;
      8'h75:   arrow_mask = 4'b1000;
      default: arrow_mask = 4'b0000;
    endcase
  endfunction

`ifdef WASD_ALIAS_EN
  logic [3:0]    ltr_held, ltr_nx;

  // Letter aliases are plain (non-extended) codes: A, D, S, W.
  function automatic logic [3:0] letter_mask(input logic [7:0] b);
    case (b)
      8'h1C:   letter_mask = 4'b0001;
      8'h23:   letter_mask = 4'b0010;
      8'h1B:   letter_mask = 4'b0100;
      8'h1D:   letter_mask = 4'b1000;
      default: letter_mask = 4'b0000;
    endcase
  endfunction
`endif

  // Two-flop synchronizers for both PS/2 lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Level filter: a new level is adopted only after FILTER_LEN consecutive differing samples;
  // the 1->0 transition is flagged as a single-cycle fall event.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_lvl <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s2 == filt_lvl) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        filt_lvl <= clk_s2;
        filt_cnt <= '0;
        fall     <= filt_lvl;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // Full frame as it stands once the current data sample is appended (bit 0 = start).
  assign frame_w   = {dat_s2, shreg};
  assign rx_byte   = frame_w[8:1];
  assign last_bit  = fall && (bit_cnt == 4'd10);
  assign frame_ok  = (frame_w[0] == 1'b0) && (frame_w[10] == 1'b1) && (^frame_w[9:1] == 1'b1);
  assign byte_vld  = last_bit && frame_ok;
  assign byte_bad  = last_bit && !frame_ok;
  // A falling edge in the expiry cycle takes priority, so expiry requires no edge.
  assign to_expire = !fall && (bit_cnt != 4'd0) && (to_cnt == TO_LAST);

  // Bit receiver: shift in LSB first, count bits, and abandon a stalled frame on timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= 4'd0;
      to_cnt  <= '0;
    end else if (fall) begin
      shreg   <= {dat_s2, shreg[9:1]};
      to_cnt  <= '0;
      bit_cnt <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
    end else if (to_expire) begin
      bit_cnt <= 4'd0;
      to_cnt  <= '0;
    end else if (bit_cnt != 4'd0) begin
      to_cnt  <= to_cnt + 1'b1;
    end else begin
      to_cnt  <= '0;
    end
  end

  // Debug outputs: last good byte and one-cycle valid/error strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_code  <= 8'h00;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= byte_vld;
      frame_err  <= byte_bad || to_expire;
      if (byte_vld) begin
        scan_code <= rx_byte;
      end
    end
  end

  // Make/break decode; evaluated on the completing edge so button moves with code_valid.
  always_comb begin
    state_nx = state;
    arr_nx   = arr_held;
`ifdef WASD_ALIAS_EN
    ltr_nx   = ltr_held;
`endif
    if (byte_bad || to_expire) begin
      state_nx = ST_IDLE;
    end else if (byte_vld) begin
      case (state)
        ST_IDLE: begin
          if (rx_byte == SC_EXT) begin
            state_nx = ST_EXT;
          end else if (rx_byte == SC_BRK) begin
            state_nx = ST_BRK;
          end else begin
`ifdef WASD_ALIAS_EN
            ltr_nx = ltr_held | letter_mask(rx_byte);
`endif
            state_nx = ST_IDLE;
          end
        end
        ST_EXT: begin
          if (rx_byte == SC_BRK) begin
            state_nx = ST_EXT_BRK;
          end else begin
            arr_nx   = arr_held | arrow_mask(rx_byte);
            state_nx = ST_IDLE;
          end
        end
        ST_BRK: begin
`ifdef WASD_ALIAS_EN
          ltr_nx = ltr_held & ~letter_mask(rx_byte);
`endif
          state_nx = ST_IDLE;
        end
        ST_EXT_BRK: begin
          arr_nx   = arr_held & ~arrow_mask(rx_byte);
          state_nx = ST_IDLE;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Decoder state and held-key flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      arr_held <= 4'b0000;
`ifdef WASD_ALIAS_EN
      ltr_held <= 4'b0000;
`endif
    end else begin
      state    <= state_nx;
      arr_held <= arr_nx;
`ifdef WASD_ALIAS_EN
      ltr_held <= ltr_nx;
`endif
    end
  end

`ifdef WASD_ALIAS_EN
  assign button = arr_held | ltr_held;
`else
  assign button = arr_held;
`endif

endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;

  localparam int TO_CYC = 1000;

  logic       clk;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] button;
  logic [7:0] scan_code;
  logic       code_valid;
  logic       frame_err;

  int nvec = 0;
  int nerr = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  logic [3:0] btn_at_valid = 4'b0000;

  ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .button(button), .scan_code(scan_code), .code_valid(code_valid), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe monitor: counts every high cycle, so a stretched strobe shows as an extra count.
  always @(negedge clk) begin
    if (code_valid) begin
      valid_cnt = valid_cnt + 1;
      btn_at_valid = button;
    end
    if (frame_err) err_cnt = err_cnt + 1;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  // 80-cycle PS/2 bit period: data settles while high, 40 cycles low, 40 high.
  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      wait_clks(20);
      ps2_clk = 1'b0;
      wait_clks(40);
      ps2_clk = 1'b1;
      wait_clks(20);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    send_bits(make_frame(b, bad_par), 11);
    wait_clks(40);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_clks(5);
    rst = 1'b0;
    wait_clks(1);
    nvec++; if (button !== 4'b0000) begin nerr++; $display("FAIL reset_button: got %b want %b", button, 4'b0000); end
    nvec++; if (scan_code !== 8'h00) begin nerr++; $display("FAIL reset_scan_code: got %h want %h", scan_code, 8'h00); end
    nvec++; if (code_valid !== 1'b0) begin nerr++; $display("FAIL reset_code_valid: got %b want 0", code_valid); end
    nvec++; if (frame_err !== 1'b0) begin nerr++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    wait_clks(50);
    nvec++; if (valid_cnt !== 0 || err_cnt !== 0) begin nerr++; $display("FAIL reset_idle_strobes: got valid=%0d err=%0d want 0/0", valid_cnt, err_cnt); end
  endtask

  task automatic test_arrow_make_break;
    int v0;
    v0 = valid_cnt;
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    nvec++; if (valid_cnt - v0 !== 2) begin nerr++; $display("FAIL arrow_make_valids: got %0d want 2", valid_cnt - v0); end
    nvec++; if (scan_code !== 8'h75) begin nerr++; $display("FAIL arrow_make_scan: got %h want 75", scan_code); end
    nvec++; if (button !== 4'b1000) begin nerr++; $display("FAIL arrow_make_button: got %b want 1000", button); end
    nvec++; if (btn_at_valid !== 4'b1000) begin nerr++; $display("FAIL arrow_button_with_valid: got %b want 1000", btn_at_valid); end
    v0 = valid_cnt;
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    nvec++; if (valid_cnt - v0 !== 3) begin nerr++; $display("FAIL arrow_break_valids: got %0d want 3", valid_cnt - v0); end
    nvec++; if (button !== 4'b0000) begin nerr++; $display("FAIL arrow_break_button: got %b want 0000", button); end
    nvec++; if (btn_at_valid !== 4'b0000) begin nerr++; $display("FAIL arrow_break_with_valid: got %b want 0000", btn_at_valid); end
  endtask

  task automatic test_parity_error;
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    send_byte(8'hE0, 1'b0);
    send_byte(8'h6B, 1'b1);
    nvec++; if (err_cnt - e0 !== 1) begin nerr++; $display("FAIL parity_err_pulse: got %0d want 1", err_cnt - e0); end
    nvec++; if (valid_cnt - v0 !== 1) begin nerr++; $display("FAIL parity_no_valid: got %0d want 1", valid_cnt - v0); end
    nvec++; if (scan_code !== 8'hE0) begin nerr++; $display("FAIL parity_scan_held: got %h want E0", scan_code); end
    nvec++; if (button !== 4'b0000) begin nerr++; $display("FAIL parity_button: got %b want 0000", button); end
    send_byte(8'h6B, 1'b0);
    nvec++; if (scan_code !== 8'h6B) begin nerr++; $display("FAIL parity_next_scan: got %h want 6B", scan_code); end
    nvec++; if (button !== 4'b0000) begin nerr++; $display("FAIL parity_next_nonext: got %b want 0000", button); end
  endtask

  task automatic test_glitch;
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    ps2_clk = 1'b0;
    wait_clks(3);
    ps2_clk = 1'b1;
    wait_clks(30);
    ps2_clk = 1'b0;
    wait_clks(7);
    ps2_clk = 1'b1;
    wait_clks(30);
    nvec++; if (valid_cnt != v0 || err_cnt != e0) begin nerr++; $display("FAIL glitch_strobes: got valid+%0d err+%0d want 0/0", valid_cnt - v0, err_cnt - e0); end
    send_byte(8'h74, 1'b0);
    nvec++; if (valid_cnt - v0 !== 1 || err_cnt != e0) begin nerr++; $display("FAIL glitch_next_frame: got valid+%0d err+%0d want 1/0", valid_cnt - v0, err_cnt - e0); end
    nvec++; if (scan_code !== 8'h74) begin nerr++; $display("FAIL glitch_next_scan: got %h want 74", scan_code); end
  endtask

  task automatic test_timeout;
    int v0, e0;
    logic [3:0] exp_btn;
    v0 = valid_cnt;
    e0 = err_cnt;
    send_bits(make_frame(8'h1C, 1'b0), 5);
    wait_clks(TO_CYC / 2);
    nvec++; if (err_cnt != e0) begin nerr++; $display("FAIL timeout_early: got err+%0d want 0", err_cnt - e0); end
    wait_clks(2 * TO_CYC);
    nvec++; if (err_cnt - e0 !== 1) begin nerr++; $display("FAIL timeout_one_pulse: got %0d want 1", err_cnt - e0); end
    nvec++; if (valid_cnt != v0) begin nerr++; $display("FAIL timeout_no_valid: got %0d want 0", valid_cnt - v0); end
    send_byte(8'h1C, 1'b0);
    nvec++; if (scan_code !== 8'h1C) begin nerr++; $display("FAIL timeout_next_scan: got %h want 1C", scan_code); end
    nvec++; if (err_cnt - e0 !== 1) begin nerr++; $display("FAIL timeout_next_noerr: got %0d want 1", err_cnt - e0); end
`ifdef WASD_ALIAS_EN
    exp_btn = 4'b0001;
`else
    exp_btn = 4'b0000;
`endif
    nvec++; if (button !== exp_btn) begin nerr++; $display("FAIL timeout_1c_button: got %b want %b", button, exp_btn); end
`ifdef WASD_ALIAS_EN
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    nvec++; if (button !== 4'b0000) begin nerr++; $display("FAIL wasd_a_break: got %b want 0000", button); end
`endif
  endtask

  task automatic test_multikey_reset;
    int v0, e0;
    send_byte(8'hE0, 1'b0);
    send_byte(8'h6B, 1'b0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'h74, 1'b0);
    nvec++; if (button !== 4'b0011) begin nerr++; $display("FAIL multikey_button: got %b want 0011", button); end
    send_bits(make_frame(8'h72, 1'b0), 5);
    rst = 1'b1;
    wait_clks(1);
    rst = 1'b0;
    wait_clks(1);
    nvec++; if (button !== 4'b0000) begin nerr++; $display("FAIL midreset_button: got %b want 0000", button); end
    nvec++; if (scan_code !== 8'h00) begin nerr++; $display("FAIL midreset_scan: got %h want 00", scan_code); end
    wait_clks(20);
    v0 = valid_cnt;
    e0 = err_cnt;
    send_byte(8'hE0, 1'b0);
    send_byte(8'h74, 1'b0);
    nvec++; if (valid_cnt - v0 !== 2 || err_cnt != e0) begin nerr++; $display("FAIL postreset_frames: got valid+%0d err+%0d want 2/0", valid_cnt - v0, err_cnt - e0); end
    nvec++; if (scan_code !== 8'h74) begin nerr++; $display("FAIL postreset_scan: got %h want 74", scan_code); end
    nvec++; if (button !== 4'b0010) begin nerr++; $display("FAIL postreset_button: got %b want 0010", button); end
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h74, 1'b0);
    nvec++; if (button !== 4'b0000) begin nerr++; $display("FAIL postreset_release: got %b want 0000", button); end
  endtask

  task automatic test_alias;
`ifdef WASD_ALIAS_EN
    send_byte(8'h1D, 1'b0);
    nvec++; if (button !== 4'b1000) begin nerr++; $display("FAIL alias_w_make: got %b want 1000", button); end
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    nvec++; if (button !== 4'b1000) begin nerr++; $display("FAIL alias_both_held: got %b want 1000", button); end
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1D, 1'b0);
    nvec++; if (button !== 4'b1000) begin nerr++; $display("FAIL alias_w_break_up_held: got %b want 1000", button); end
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    nvec++; if (button !== 4'b0000) begin nerr++; $display("FAIL alias_all_released: got %b want 0000", button); end
`else
    send_byte(8'h1D, 1'b0);
    nvec++; if (scan_code !== 8'h1D) begin nerr++; $display("FAIL alias_off_scan: got %h want 1D", scan_code); end
    nvec++; if (button !== 4'b0000) begin nerr++; $display("FAIL alias_off_button: got %b want 0000", button); end
`endif
  endtask

  initial begin
    test_reset;
    test_arrow_make_break;
    test_parity_error;
    test_glitch;
    test_timeout;
    test_multikey_reset;
    test_alias;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Upstream input stage of the game: receives raw PS/2 keyboard clock/data, assembles and validates 11-bit frames, and decodes scan-code set 2 make/break sequences.
- Drives a 4-bit held-button vector consumed by the game core: bit 0 left, 1 right, 2 down, 3 up.
- Also exposes the last raw byte plus valid/error strobes for debug.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronized ps2_clk samples required before the filtered level changes.
- TIMEOUT_CYCLES, 100000: clk cycles with no filtered ps2_clk falling edge, while mid-frame, before the frame is abandoned.

Ports:
- clk  input  1  system clock; only clock domain.
- rst  input  1  synchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock, asynchronous.
- ps2_data  input  1  raw PS/2 data, asynchronous.
- button  output  4  held state: [0] left, [1] right, [2] down, [3] up.
- scan_code  output  8  last correctly framed byte.
- code_valid  output  1  one-cycle strobe when scan_code updates.
- frame_err  output  1  one-cycle strobe on a bad frame or timeout.

Behaviour:
- Reset state: button=0, scan_code=0x00, code_valid=0, frame_err=0, bit count=0, decoder in IDLE, filtered clock level=1.
- Reset is sampled on clk only and wins over all other events. Reset mid-frame discards the partial frame.
- Input conditioning:
  - 2-FF synchronizer on ps2_clk and ps2_data.
  - Filtered clock changes level only after FILTER_LEN equal consecutive synchronized samples.
  - A falling edge is filtered level going 1->0, registered as a single-cycle event.
- Framing (receiver):
  - Each falling edge samples synchronized ps2_data into an 11-bit shift register, LSB first, and increments bit count 0..10.
  - Frame order: start, d0..d7, parity, stop.
  - On the 11th bit, bit count wraps to 0 and the frame is checked: start==0, stop==1, and odd parity (d0..d7 plus parity bit has an odd number of 1s).
  - Pass: on the next cycle, scan_code<=data and code_valid=1 for 1 cycle.
  - Fail: on the next cycle, frame_err=1 for 1 cycle; scan_code is unchanged; decoder returns to IDLE; button is unchanged.
- Timeout:
  - Counter clears on every falling edge and increments while bit count!=0.
  - Reaching TIMEOUT_CYCLES sets bit count=0, frame_err=1 for one cycle, decoder to IDLE.
  - If a falling edge and timeout expiry occur in the same cycle, the edge wins: the bit is accepted and no error is raised.
- Decoder FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0). It advances only on code_valid.
  - IDLE: E0->EXT; F0->BRK; any other byte: apply non-extended make, stay IDLE.
  - EXT: F0->EXT_BRK; any other byte: apply extended make, ->IDLE.
  - BRK: apply non-extended break, ->IDLE.
  - EXT_BRK: apply extended break, ->IDLE.
- Extended map: 6B left, 74 right, 72 down, 75 up. Make sets the bit; break clears it.
- Unmapped codes, including E1 and typematic repeats of an already-set key, leave button unchanged. Repeats are idempotent.
- button updates in the same cycle code_valid is high. Total latency is 1 cycle from the filtered falling edge that samples the stop bit.
- Multiple bits of button may be high at once. Opposing directions are not arbitrated here.

Optional Feature:
- Macro: WASD_ALIAS_EN.
- Defined: non-extended codes also drive button, with make sets and break clears:
  - 1C (A) -> left
  - 23 (D) -> right
  - 1B (S) -> down
  - 1D (W) -> up
- Each physical key drives its own internal held flag. A button bit is the OR of its arrow flag and its letter flag, so releasing one key while the other is held keeps the bit set.
- Undefined: non-extended codes never affect button. Only the arrow-key map applies.

Test Plan:
- Bench PS/2 timing: clock period 80 clk cycles with FILTER_LEN=8.
- Arrow make/break: frames E0, 75 -> button=4'b1000 with code_valid on each byte and scan_code=0x75; then E0, F0, 75 -> button=4'b0000.
- Parity error: byte 0x6B sent with even parity after E0 -> frame_err pulse, no code_valid, button unchanged; a following valid 0x6B is treated as non-extended and leaves button=0.
- Timeout: send 5 bits, then hold ps2_clk high for TIMEOUT_CYCLES -> exactly one frame_err pulse; the next full frame 0x1C decodes with scan_code=0x1C.
- Glitch rejection: ps2_clk low pulses of 3 clk cycles mid-idle -> bit count stays 0, no strobes.
- Multi-key and reset: hold left (E0 6B) and right (E0 74) -> button=4'b0011; assert rst for 1 cycle mid-frame -> button=0, scan_code=0x00, next clean frame decodes.
- WASD_ALIAS_EN defined: make 1D, make E0 75, break F0 1D -> button[3] stays 1; then E0 F0 75 -> button[3]=0. Undefined: 1D leaves button=0.
